// File: rtl/axi_full_slave_sram_pkg.sv
// Shared definitions for the AXI4 SRAM slave: burst and response encodings,
// channel FSM state types and the burst address-advance helper.
package axi_full_slave_sram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Byte address of the next beat. Reserved burst type 3 behaves as INCR.
  // WRAP keeps the address inside the (len+1)*2**size aligned window.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [7:0]  len,
                                            input logic [1:0]  burst);
    logic [31:0] incr_s;
    logic [31:0] mask_s;
    logic [31:0] result_s;
    incr_s = 32'd1 << size;
    mask_s = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      BURST_FIXED: result_s = addr;
      BURST_WRAP:  result_s = (addr & ~mask_s) | ((addr + incr_s) & mask_s);
      default:     result_s = addr + incr_s;
    endcase
    return result_s;
  endfunction

endpackage

// File: rtl/axi_full_slave_sram_sram_bytewr.sv
// Word-organised SRAM with a byte-enable write port and a registered read
// port. The ram array carries no reset so it can be preloaded by backdoor.
module sram_bytewr #(
  parameter int DW = 128,
  parameter int AW = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [DW/8-1:0]   wstrb,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] ram [0:2**AW-1];
  logic [DW-1:0] rdata_r;

  // Byte-lane write: only strobed bytes of the addressed word change.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wstrb[b]) begin
          ram[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered read; a same-edge write is not forwarded (old data returned).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DW{1'b0}};
    end else if (re) begin
      rdata_r <= ram[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/axi_full_slave_sram.sv
// AXI4 slave fronting a byte-writable SRAM. Independent read and write
// channel FSMs; all responses are OKAY; WLAST is ignored (LEN terminates).
module axi_full_slave_sram
  import axi_full_slave_sram_pkg::*;
#(
  parameter int DW = 128,
  parameter int AW = 14
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic [31:0]     MEM_AWADDR,
  input  logic [7:0]      MEM_AWLEN,
  input  logic [2:0]      MEM_AWSIZE,
  input  logic [1:0]      MEM_AWBURST,
  input  logic            MEM_AWVALID,
  output logic            MEM_AWREADY,
  input  logic [DW-1:0]   MEM_WDATA,
  input  logic [DW/8-1:0] MEM_WSTRB,
  input  logic            MEM_WLAST,
  input  logic            MEM_WVALID,
  output logic            MEM_WREADY,
  output logic [1:0]      MEM_BRESP,
  output logic            MEM_BVALID,
  input  logic            MEM_BREADY,
  input  logic [31:0]     MEM_ARADDR,
  input  logic [7:0]      MEM_ARLEN,
  input  logic [2:0]      MEM_ARSIZE,
  input  logic [1:0]      MEM_ARBURST,
  input  logic            MEM_ARVALID,
  output logic            MEM_ARREADY,
  output logic [DW-1:0]   MEM_RDATA,
  output logic [1:0]      MEM_RRESP,
  output logic            MEM_RLAST,
  output logic            MEM_RVALID,
  input  logic            MEM_RREADY
);

  localparam int OFF = $clog2(DW/8);

  wr_state_t   w_state_r, w_next_s;
  rd_state_t   r_state_r, r_next_s;
  logic [31:0] waddr_r, raddr_r, r_next_addr_s;
  logic [7:0]  wlen_r, wcnt_r, rlen_r, rcnt_r;
  logic [2:0]  wsize_r, rsize_r;
  logic [1:0]  wburst_r, rburst_r;
  logic        awready_r, wready_r, bvalid_r, arready_r, rvalid_r, rlast_r;
  logic        aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, w_last_s, r_last_s;
  logic        sram_re_s;
  logic [AW-1:0] sram_raddr_s;
  logic        unused_s;

  assign aw_hs_s  = MEM_AWVALID & awready_r;
  assign w_hs_s   = MEM_WVALID & wready_r;
  assign b_hs_s   = MEM_BREADY & bvalid_r;
  assign ar_hs_s  = MEM_ARVALID & arready_r;
  assign r_hs_s   = MEM_RREADY & rvalid_r;
  assign w_last_s = (wcnt_r == wlen_r);
  assign r_last_s = (rcnt_r == rlen_r);
  assign unused_s = MEM_WLAST;

  // ---------------- write channel ----------------

  // Write FSM state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) w_state_r <= W_IDLE;
    else       w_state_r <= w_next_s;
  end

  // Write FSM next-state: address, LEN+1 data beats, then the B response.
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_IDLE: if (aw_hs_s) w_next_s = W_DATA; else w_next_s = W_IDLE;
      W_DATA: if (w_hs_s && w_last_s) w_next_s = W_RESP; else w_next_s = W_DATA;
      W_RESP: if (b_hs_s) w_next_s = W_IDLE; else w_next_s = W_RESP;
      default: w_next_s = W_IDLE;
    endcase
  end

  // Write channel handshake outputs, registered from the next state.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
    end else begin
      awready_r <= (w_next_s == W_IDLE);
      wready_r  <= (w_next_s == W_DATA);
      bvalid_r  <= (w_next_s == W_RESP);
    end
  end

  // Write burst bookkeeping: capture AW fields, advance address per beat.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      waddr_r  <= 32'd0;
      wlen_r   <= 8'd0;
      wsize_r  <= 3'd0;
      wburst_r <= 2'd0;
      wcnt_r   <= 8'd0;
    end else if (aw_hs_s) begin
      waddr_r  <= MEM_AWADDR;
      wlen_r   <= MEM_AWLEN;
      wsize_r  <= MEM_AWSIZE;
      wburst_r <= MEM_AWBURST;
      wcnt_r   <= 8'd0;
    end else if (w_hs_s) begin
      waddr_r  <= next_addr(waddr_r, wsize_r, wlen_r, wburst_r);
      wcnt_r   <= wcnt_r + 8'd1;
    end
  end

  // ---------------- read channel ----------------

  // Read FSM state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state_r <= R_IDLE;
    else       r_state_r <= r_next_s;
  end

  // Read FSM next-state: leave R_DATA on the handshake of the last beat.
  always_comb begin
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE: if (ar_hs_s) r_next_s = R_DATA; else r_next_s = R_IDLE;
      R_DATA: if (r_hs_s && r_last_s) r_next_s = R_IDLE; else r_next_s = R_DATA;
      default: r_next_s = R_IDLE;
    endcase
  end

  // Read channel handshake outputs, registered from the next state.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
    end else begin
      arready_r <= (r_next_s == R_IDLE);
      rvalid_r  <= (r_next_s == R_DATA);
    end
  end

  assign r_next_addr_s = next_addr(raddr_r, rsize_r, rlen_r, rburst_r);

  // SRAM read request: fetch the first beat on AR, the next beat on each
  // non-final R handshake, so RDATA is ready the cycle RVALID is shown.
  always_comb begin
    sram_re_s = ar_hs_s | (r_hs_s & ~r_last_s);
    if (ar_hs_s) sram_raddr_s = MEM_ARADDR[AW+OFF-1:OFF];
    else         sram_raddr_s = r_next_addr_s[AW+OFF-1:OFF];
  end

  // Read burst bookkeeping: tracks the address and beat number being shown.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      raddr_r  <= 32'd0;
      rlen_r   <= 8'd0;
      rsize_r  <= 3'd0;
      rburst_r <= 2'd0;
      rcnt_r   <= 8'd0;
      rlast_r  <= 1'b0;
    end else if (ar_hs_s) begin
      raddr_r  <= MEM_ARADDR;
      rlen_r   <= MEM_ARLEN;
      rsize_r  <= MEM_ARSIZE;
      rburst_r <= MEM_ARBURST;
      rcnt_r   <= 8'd0;
      rlast_r  <= (MEM_ARLEN == 8'd0);
    end else if (r_hs_s) begin
      raddr_r  <= r_next_addr_s;
      rcnt_r   <= rcnt_r + 8'd1;
      if (r_last_s) rlast_r <= 1'b0;
      else          rlast_r <= ((rcnt_r + 8'd1) == rlen_r);
    end
  end

  sram_bytewr #(.DW(DW), .AW(AW)) i_sram (
    .clk   (CLK),
    .rst_n (RSTn),
    .we    (w_hs_s),
    .waddr (waddr_r[AW+OFF-1:OFF]),
    .wdata (MEM_WDATA),
    .wstrb (MEM_WSTRB),
    .re    (sram_re_s),
    .raddr (sram_raddr_s),
    .rdata (MEM_RDATA)
  );

  assign MEM_AWREADY = awready_r;
  assign MEM_WREADY  = wready_r;
  assign MEM_BVALID  = bvalid_r;
  assign MEM_BRESP   = RESP_OKAY;
  assign MEM_ARREADY = arready_r;
  assign MEM_RVALID  = rvalid_r;
  assign MEM_RLAST   = rlast_r;
  assign MEM_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_axi_full_slave_sram.sv
// Directed bench for axi_full_slave_sram: expected read beats are queued
// when a read is issued and compared as R beats are accepted.
module tb_axi_full_slave_sram;

  logic         CLK = 1'b0;
  logic         RSTn;
  logic [31:0]  MEM_AWADDR, MEM_ARADDR;
  logic [7:0]   MEM_AWLEN, MEM_ARLEN;
  logic [2:0]   MEM_AWSIZE, MEM_ARSIZE;
  logic [1:0]   MEM_AWBURST, MEM_ARBURST;
  logic         MEM_AWVALID, MEM_AWREADY, MEM_ARVALID, MEM_ARREADY;
  logic [127:0] MEM_WDATA, MEM_RDATA;
  logic [15:0]  MEM_WSTRB;
  logic         MEM_WLAST, MEM_WVALID, MEM_WREADY;
  logic [1:0]   MEM_BRESP, MEM_RRESP;
  logic         MEM_BVALID, MEM_BREADY;
  logic         MEM_RLAST, MEM_RVALID, MEM_RREADY;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] exp_q [$];
  logic [127:0] wdata_q [$];
  logic [127:0] model [0:15];

  always #5 CLK = ~CLK;

  axi_full_slave_sram #(.DW(128), .AW(14)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN), .MEM_AWSIZE(MEM_AWSIZE),
    .MEM_AWBURST(MEM_AWBURST), .MEM_AWVALID(MEM_AWVALID), .MEM_AWREADY(MEM_AWREADY),
    .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST),
    .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
    .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY),
    .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN), .MEM_ARSIZE(MEM_ARSIZE),
    .MEM_ARBURST(MEM_ARBURST), .MEM_ARVALID(MEM_ARVALID), .MEM_ARREADY(MEM_ARREADY),
    .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP), .MEM_RLAST(MEM_RLAST),
    .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Backdoor preload; nonblocking so it orders like the RAM's own writes.
  task automatic backdoor(input int idx, input logic [127:0] val);
    dut.i_sram.ram[idx] <= val;
    model[idx] = val;
  endtask

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d,
                                         input logic [15:0] strb);
    logic [127:0] r;
    r = old;
    for (int b = 0; b < 16; b++) if (strb[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int n;
    MEM_ARADDR = addr; MEM_ARLEN = len; MEM_ARSIZE = 3'd4; MEM_ARBURST = burst;
    MEM_ARVALID = 1'b1;
    n = 0;
    while (MEM_ARREADY !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    if (n >= 20) check("ar_timeout", 128'd0, 128'd1);
    @(negedge CLK);
    MEM_ARVALID = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int n;
    MEM_AWADDR = addr; MEM_AWLEN = len; MEM_AWSIZE = 3'd4; MEM_AWBURST = burst;
    MEM_AWVALID = 1'b1;
    n = 0;
    while (MEM_AWREADY !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    if (n >= 20) check("aw_timeout", 128'd0, 128'd1);
    @(negedge CLK);
    MEM_AWVALID = 1'b0;
    check("wready_after_aw", {127'd0, MEM_WREADY}, 128'd1);
  endtask

  // Accept nbeats R beats, comparing each against the scoreboard queue.
  // On beat stall_beat RREADY is dropped for two cycles and hold is checked.
  task automatic r_collect(input int nbeats, input string tag, input int stall_beat);
    int n;
    logic [127:0] e;
    check({tag, "_rvalid_latency"}, {127'd0, MEM_RVALID}, 128'd1);
    MEM_RREADY = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      n = 0;
      while (MEM_RVALID !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
      if (n >= 20) check($sformatf("%s_rvalid_timeout%0d", tag, i), 128'd0, 128'd1);
      if (exp_q.size() == 0) begin
        check($sformatf("%s_queue_empty%0d", tag, i), 128'd0, 128'd1);
        e = 128'd0;
      end else begin
        e = exp_q.pop_front();
      end
      check($sformatf("%s_rdata%0d", tag, i), MEM_RDATA, e);
      check($sformatf("%s_rlast%0d", tag, i), {127'd0, MEM_RLAST}, {127'd0, (i == nbeats - 1)});
      check($sformatf("%s_rresp%0d", tag, i), {126'd0, MEM_RRESP}, 128'd0);
      if (i == stall_beat) begin
        MEM_RREADY = 1'b0;
        repeat (2) @(negedge CLK);
        check($sformatf("%s_hold_rvalid%0d", tag, i), {127'd0, MEM_RVALID}, 128'd1);
        check($sformatf("%s_hold_rdata%0d", tag, i), MEM_RDATA, e);
        check($sformatf("%s_hold_rlast%0d", tag, i), {127'd0, MEM_RLAST}, {127'd0, (i == nbeats - 1)});
        MEM_RREADY = 1'b1;
      end
      @(negedge CLK);
    end
    MEM_RREADY = 1'b0;
    check({tag, "_rvalid_end"}, {127'd0, MEM_RVALID}, 128'd0);
    check({tag, "_arready_end"}, {127'd0, MEM_ARREADY}, 128'd1);
  endtask

  // INCR write burst of size 16 using wdata_q; updates the bench model.
  task automatic w_burst(input logic [31:0] addr, input int len, input logic [15:0] strb);
    int n;
    int base;
    logic [127:0] d;
    base = int'(addr >> 4);
    aw_send(addr, 8'(len), 2'd1);
    for (int i = 0; i <= len; i++) begin
      d = wdata_q.pop_front();
      MEM_WDATA = d; MEM_WSTRB = strb; MEM_WLAST = (i == len); MEM_WVALID = 1'b1;
      n = 0;
      while (MEM_WREADY !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
      if (n >= 20) check("wready_timeout", 128'd0, 128'd1);
      @(negedge CLK);
      model[(base + i) & 15] = merge(model[(base + i) & 15], d, strb);
    end
    MEM_WVALID = 1'b0; MEM_WLAST = 1'b0;
    check("bvalid_after_last", {127'd0, MEM_BVALID}, 128'd1);
    check("bresp_okay", {126'd0, MEM_BRESP}, 128'd0);
    check("awready_in_resp", {127'd0, MEM_AWREADY}, 128'd0);
    MEM_BREADY = 1'b1;
    @(negedge CLK);
    MEM_BREADY = 1'b0;
    check("bvalid_cleared", {127'd0, MEM_BVALID}, 128'd0);
    check("awready_back", {127'd0, MEM_AWREADY}, 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn = 1'b0;
    MEM_AWADDR = 32'd0; MEM_AWLEN = 8'd0; MEM_AWSIZE = 3'd0; MEM_AWBURST = 2'd0; MEM_AWVALID = 1'b0;
    MEM_ARADDR = 32'd0; MEM_ARLEN = 8'd0; MEM_ARSIZE = 3'd0; MEM_ARBURST = 2'd0; MEM_ARVALID = 1'b0;
    MEM_WDATA = 128'd0; MEM_WSTRB = 16'd0; MEM_WLAST = 1'b0; MEM_WVALID = 1'b0;
    MEM_BREADY = 1'b0; MEM_RREADY = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 128'd0;

    // Reset: outputs quiet while held, ready to accept right after release.
    repeat (2) @(negedge CLK);
    check("rst_awready", {127'd0, MEM_AWREADY}, 128'd0);
    check("rst_arready", {127'd0, MEM_ARREADY}, 128'd0);
    check("rst_wready",  {127'd0, MEM_WREADY},  128'd0);
    check("rst_bvalid",  {127'd0, MEM_BVALID},  128'd0);
    check("rst_rvalid",  {127'd0, MEM_RVALID},  128'd0);
    check("rst_rlast",   {127'd0, MEM_RLAST},   128'd0);
    check("rst_rdata",   MEM_RDATA, 128'd0);
    check("rst_resps",   {124'd0, MEM_BRESP, MEM_RRESP}, 128'd0);
    RSTn = 1'b1;
    @(negedge CLK);
    check("post_rst_awready", {127'd0, MEM_AWREADY}, 128'd1);
    check("post_rst_arready", {127'd0, MEM_ARREADY}, 128'd1);

    // Backdoor word 0, read it through the aliased high address.
    backdoor(0, 128'h00112233445566778899AABBCCDDEEFF);
    @(negedge CLK);
    ar_send(32'h8000_0000, 8'd0, 2'd1);
    exp_q.push_back(128'h00112233445566778899AABBCCDDEEFF);
    r_collect(1, "alias", -1);

    // INCR write of four beats at 0x40 (words 4..7), then read back.
    for (int k = 0; k < 4; k++) wdata_q.push_back(128'(k));
    w_burst(32'h40, 3, 16'hFFFF);
    ar_send(32'h40, 8'd3, 2'd1);
    for (int k = 0; k < 4; k++) exp_q.push_back(128'(k));
    r_collect(4, "incr", -1);

    // Partial write: only byte 0 of word 5 may change.
    backdoor(5, 128'h0F0E0D0C0B0A09080706050403020100);
    @(negedge CLK);
    wdata_q.push_back(128'h555555555555555555555555555555AA);
    w_burst(32'h50, 0, 16'h0001);
    ar_send(32'h50, 8'd0, 2'd1);
    exp_q.push_back(128'h0F0E0D0C0B0A090807060504030201AA);
    r_collect(1, "strb", -1);

    // WRAP read from 0x30 over a 64-byte window: words 3,0,1,2, stall on beat 1.
    for (int k = 0; k < 4; k++) backdoor(k, {4{32'hC0DE_0000 + 32'(k)}});
    @(negedge CLK);
    ar_send(32'h30, 8'd3, 2'd2);
    exp_q.push_back({4{32'hC0DE_0003}});
    exp_q.push_back({4{32'hC0DE_0000}});
    exp_q.push_back({4{32'hC0DE_0001}});
    exp_q.push_back({4{32'hC0DE_0002}});
    r_collect(4, "wrap", 1);

    // FIXED read of three beats at 0x20: word 2 each time, stall on last beat.
    ar_send(32'h20, 8'd2, 2'd0);
    for (int k = 0; k < 3; k++) exp_q.push_back({4{32'hC0DE_0002}});
    r_collect(3, "fixed", 2);

    // Reset during W_DATA after one of four beats: only beat 0 lands.
    for (int k = 8; k < 12; k++) backdoor(k, {4{32'hBEEF_0000 + 32'(k)}});
    @(negedge CLK);
    aw_send(32'h80, 8'd3, 2'd1);
    MEM_WDATA = 128'hD0D0_D0D0_D0D0_D0D0_D0D0_D0D0_D0D0_D0D0;
    MEM_WSTRB = 16'hFFFF; MEM_WVALID = 1'b1;
    @(negedge CLK);
    model[8] = 128'hD0D0_D0D0_D0D0_D0D0_D0D0_D0D0_D0D0_D0D0;
    MEM_WDATA = 128'hD1D1_D1D1_D1D1_D1D1_D1D1_D1D1_D1D1_D1D1;
    #1;
    RSTn = 1'b0;
    MEM_WVALID = 1'b0;
    #1;
    check("mid_rst_wready",  {127'd0, MEM_WREADY},  128'd0);
    check("mid_rst_awready", {127'd0, MEM_AWREADY}, 128'd0);
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    check("after_rst_awready", {127'd0, MEM_AWREADY}, 128'd1);
    check("after_rst_wready",  {127'd0, MEM_WREADY},  128'd0);
    ar_send(32'h80, 8'd3, 2'd1);
    for (int k = 8; k < 12; k++) exp_q.push_back(model[k]);
    r_collect(4, "abort", -1);

    check("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_full_slave_sram.md
# axi_full_slave_sram

AXI4 full slave with a single-port-per-channel word-addressed SRAM behind it; the main memory model of the Rift2 chip-level bench. It accepts independent read and write bursts from the core's memory channel and returns OKAY responses. Contents are preloadable by hierarchical backdoor through the SRAM sub-module's `ram` array.

## Interface
- DW, 128: data width in bits; power of two, ≥ 8.
- AW, 14: word-address bits; depth = 2**AW words of DW bits.
- CLK  in  1  clock, all logic on rising edge.
- RSTn  in  1  reset, asynchronous and active-low.
- MEM_AWADDR / MEM_ARADDR  in  32  byte address.
- MEM_AWLEN / MEM_ARLEN  in  8  beats − 1.
- MEM_AWSIZE / MEM_ARSIZE  in  3  bytes per beat = 2**SIZE.
- MEM_AWBURST / MEM_ARBURST  in  2  0 FIXED, 1 INCR, 2 WRAP.
- MEM_AWVALID / MEM_ARVALID  in  1;  MEM_AWREADY / MEM_ARREADY  out  1.
- MEM_WDATA  in  DW;  MEM_WSTRB  in  DW/8;  MEM_WLAST  in  1;  MEM_WVALID  in  1;  MEM_WREADY  out  1.
- MEM_BRESP  out  2;  MEM_BVALID  out  1;  MEM_BREADY  in  1.
- MEM_RDATA  out  DW;  MEM_RRESP  out  2;  MEM_RLAST  out  1;  MEM_RVALID  out  1;  MEM_RREADY  in  1.

## Operation
- Word index = ADDR[AW+log2(DW/8)−1 : log2(DW/8)]; higher address bits ignored (0x8000_0000 aliases word 0).
- Write FSM: W_IDLE (AWREADY=1) → AW handshake captures addr/len/size/burst → W_DATA (WREADY=1); each W handshake writes bytes enabled by WSTRB to current word, then advances address; beat counter reaching LEN ends burst (WLAST not used for termination) → W_RESP (BVALID=1, BRESP=2'b00) → B handshake → W_IDLE.
- Read FSM: R_IDLE (ARREADY=1) → AR handshake captures fields → R_DATA (RVALID=1, RRESP=2'b00, RLAST=1 on beat LEN); each R handshake advances; handshake on last beat → R_IDLE.
- Address advance: FIXED holds; INCR adds 2**SIZE bytes; WRAP adds 2**SIZE and wraps within a (LEN+1)·2**SIZE-byte aligned window (LEN ∈ {1,3,7,15}); burst value 3 treated as INCR.
- Narrow beats select the word containing the address; byte lanes governed solely by WSTRB; RDATA always the full word.
- Read and write channels fully independent and concurrent.

## Timing
- While RSTn low: all READY/VALID outputs 0, RLAST 0, RDATA 0, BRESP/RRESP 0; FSMs to idle. Memory contents not cleared.
- First cycle after reset release: AWREADY=ARREADY=1.
- AW handshake at edge T → WREADY=1 from T+1; write commits at the W-handshake edge.
- Last W beat at T → BVALID=1 from T+1 until BREADY sampled high.
- AR handshake at T → first beat RVALID=1 from T+1; one beat per cycle while RREADY held high; RVALID/RDATA/RLAST stable while RREADY low.
- Read of a word written on the same edge returns pre-write data; following beat/cycle returns new data.
- AWREADY low outside W_IDLE; ARREADY low outside R_IDLE.
- Reset asserted mid-burst aborts the burst immediately; no partial state survives.

## Structure
- Shared package: burst encodings (FIXED/INCR/WRAP), RESP_OKAY=2'b00, FSM state enums, next-address function (addr, size, len, burst).
- One sub-module `sram_bytewr`, instance name `i_sram`: array `ram[0:2**AW−1]` of DW bits, byte-enable write port, read port; `ram` must remain hierarchically accessible for backdoor preload.

## Test plan
- Reset: hold RSTn low 2 cycles → all VALIDs 0; first cycle after release AWREADY=ARREADY=1.
- Backdoor ram[0]=128'h0011…EEFF; AR addr 0x8000_0000 len 0 INCR size 4 → RVALID next cycle, RDATA=ram[0], RLAST=1, RRESP=0.
- INCR write len 3 at 0x40 with full strobe, data k=0..3 → BVALID one cycle after 4th beat, BRESP=0; read back 0x40 len 3 returns 0..3 in order, RLAST only on beat 4.
- Partial write WSTRB=16'h0001 data 0xAA to word 5 → only byte 0 changes, other 15 bytes preserved.
- WRAP read len 3 size 4 start 0x30 → words 3,0,1,2; FIXED read len 2 at 0x20 → word 2 three times.
- RREADY toggled low mid-burst → RDATA/RLAST held stable; reset asserted during W_DATA → WREADY 0, AWREADY 1 after release, memory unchanged for un-sent beats.
